sd_sector_arbiter: RTL
======================

# sd_sector_arbiter

Sequences the hps_io virtual-SD sector handshake (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack` plus the 512-byte buffer bus) and shares it between two requesters inside the MultiComp core, for example the Microcomputer's SD/CP/M disk path and a second disk image.
- Round-robin arbitration on whole-sector transactions.
- Sequences the rd/wr/ack handshake and steers the buffer bus to the granted requester.
- Reports per-requester completion, and optionally a timeout error.

## Interface
- `TIMEOUT_CYCLES`, default 24'd12_000_000: cycles spent in REQ without `sd_ack` before abort (used only with the macro).
- `clk_sys` in 1: core clock; same clock as hps_io.
- `RESET_N` in 1: asynchronous, active-low reset.
- `rN_rd`, `rN_wr` (N=0,1) in 1 each: level request, held until `rN_done`/`rN_err`; if both are high, read wins.
- `rN_lba` in 32: sector address; sampled at grant.
- `rN_done` out 1: one-cycle completion pulse.
- `rN_err` out 1: one-cycle timeout pulse.
- `rN_buff_addr` out 9, `rN_buff_dout` out 8, `rN_buff_wr` out 1: buffer bus forwarded to requester N.
- `rN_buff_din` in 8: requester N write data.
- `sd_lba` out 32, `sd_rd` out 1, `sd_wr` out 1: to hps_io.
- `sd_ack` in 1: from hps_io, synchronous to `clk_sys`.
- `sd_buff_addr` in 9, `sd_buff_dout` in 8, `sd_buff_wr` in 1: from hps_io.
- `sd_buff_din` out 8: to hps_io.
- `busy` out 1: state is not IDLE.
- `grant` out 1: current or last owner index.

## Operation
- **States:** IDLE, REQ, XFER, DONE.
- **IDLE:**
  - If exactly one requester asserts rd|wr, grant it.
  - If both assert, grant `!last_grant`.
  - On grant: latch `rN_lba` into `sd_lba`; latch direction; go to REQ.
- **REQ:**
  - Hold `sd_rd` (read) or `sd_wr` (write) high.
  - On `sd_ack`=1, clear `sd_rd`/`sd_wr` and go to XFER.
- **XFER:**
  - Stay while `sd_ack`=1.
  - On `sd_ack`=0, go to DONE.
- **DONE:**
  - Pulse `rN_done` for the granted requester.
  - Set `last_grant` = grant; go to IDLE.
- **Buffer steering (combinational):**
  - Active when (state==REQ|XFER) && `sd_ack`.
  - Granted requester's `rN_buff_addr`/`rN_buff_dout`/`rN_buff_wr` follow the `sd_buff_*` inputs.
  - `sd_buff_din` = granted requester's `rN_buff_din`.
  - Otherwise all forwarded outputs and `sd_buff_din` are 0.
  - Non-granted requester always sees 0s.
- Request withdrawn during REQ/XFER is ignored; the transaction completes and `done` still pulses.
- A requester still asserting in the IDLE cycle after DONE is treated as a new request.
- Spurious `sd_ack` in IDLE or DONE: ignored; no buffer forwarding.
- `rN_lba` changes after grant have no effect.
- **Reset (any state, including mid-transfer):**
  - State = IDLE.
  - `sd_rd`, `sd_wr`, `sd_lba`, `rN_done`, `rN_err`, `busy`, `grant` all 0.
  - `last_grant` = 1, so r0 wins the first tie.

## Timing
- Request seen in IDLE at cycle t → at t+1: `sd_rd`/`sd_wr` high, `sd_lba` valid, `busy`=1, `grant` valid.
- `sd_ack` sampled high at cycle a → `sd_rd`/`sd_wr` low at a+1.
- `sd_ack` sampled low at cycle f (in XFER) → `rN_done`=1 at f+1 only; IDLE at f+2; earliest next `sd_rd` at f+3.
- Buffer steering has zero latency; same-cycle `sd_buff_wr` is forwarded.
- Throughput: one sector per arbitration; no pipelining between transactions.

## Configuration
- **`SD_ARB_TIMEOUT_EN` defined:**
  - A 24-bit counter clears on entry to REQ and increments each REQ cycle.
  - When count == `TIMEOUT_CYCLES`-1 and `sd_ack`=0: next cycle drop `sd_rd`/`sd_wr`, pulse `rN_err` for one cycle, set `last_grant` = grant, go to IDLE (no `done`).
  - `sd_ack` on the same cycle as expiry wins: normal path, no error.
- **Not defined:** no counter; REQ waits indefinitely; `rN_err` tied 0.

## Test plan
- **Single read:** r0_rd=1, r0_lba=0x00000123; hps model acks 5 cycles later and writes 512 bytes → `sd_lba`=0x123; `sd_rd` drops 1 cycle after ack; r0 sees 512 `buff_wr` pulses with matching addr/data; r1 sees none; `r0_done` exactly one pulse.
- **Simultaneous requests:** r0_rd and r1_wr both high from reset → r0 served first, then r1; `sd_wr`=1 for r1 with r1_lba; `sd_buff_din` mirrors `r1_buff_din`; one `done` each, in order.
- **Fairness:** r0 holds rd continuously, r1 asserts rd during r0's XFER → next grant goes to r1, not r0.
- **Reset mid-XFER:** assert `RESET_N`=0 while `sd_ack`=1 → all outputs 0 asynchronously; after release, a fresh r1 request completes normally.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** r0_rd with no ack → `sd_rd` high for 16 cycles, then low; `r0_err` one pulse; `r0_done` never. Macro off: `sd_rd` still high after 1000 cycles.
- **Spurious ack:** `sd_ack` pulses with `sd_buff_wr` in IDLE → no forwarded writes; state stays IDLE.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
//   Shares the hps_io virtual-SD sector handshake between two requesters.
//   Arbitration is round-robin and works on whole sectors. The block drives
//   the sd_rd/sd_wr/sd_ack handshake and routes the 512-byte buffer bus to the
//   requester that holds the grant.
//
//   Optional feature: when SD_ARB_TIMEOUT_EN is defined, a REQ that gets no
//   sd_ack within TIMEOUT_CYCLES cycles is aborted and reported on rN_err.
//   When the macro is not defined, REQ waits with no limit and rN_err is tied 0.
//
// Ports
//   clk_sys, RESET_N          core clock, asynchronous active-low reset
//   rN_rd / rN_wr             level requests, held until rN_done/rN_err
//                             (read wins if both are high)
//   rN_lba                    sector address, sampled at grant
//   rN_done / rN_err          one-cycle completion / timeout pulses
//   rN_buff_addr/dout/wr      buffer bus forwarded to requester N
//   rN_buff_din               requester N write data
//   sd_lba/sd_rd/sd_wr        command to hps_io
//   sd_ack, sd_buff_*         handshake and buffer bus from hps_io
//   sd_buff_din               write data to hps_io
//   busy                      state is not IDLE
//   grant                     current or last owner index
module sd_sector_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,

  input  logic        r0_rd,
  input  logic        r0_wr,
  input  logic [31:0] r0_lba,
  output logic        r0_done,
  output logic        r0_err,
  output logic [8:0]  r0_buff_addr,
  output logic [7:0]  r0_buff_dout,
  output logic        r0_buff_wr,
  input  logic [7:0]  r0_buff_din,

  input  logic        r1_rd,
  input  logic        r1_wr,
  input  logic [31:0] r1_lba,
  output logic        r1_done,
  output logic        r1_err,
  output logic [8:0]  r1_buff_addr,
  output logic [7:0]  r1_buff_dout,
  output logic        r1_buff_wr,
  input  logic [7:0]  r1_buff_din,

  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,

  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic last_grant;
  logic dir_wr;
  logic req0, req1;
  logic pick;
  logic pick_wr;
  logic fwd;
  logic timeout_hit;
  logic err_pulse;

  assign req0 = r0_rd | r0_wr;
  assign req1 = r1_rd | r1_wr;

  // On a tie, the requester that was not served last gets the grant.
  assign pick    = (req0 && req1) ? ~last_grant : req1;
  assign pick_wr = pick ? ~r1_rd : ~r0_rd;

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt;

  // If sd_ack arrives in the same cycle as the expiry, the normal path wins.
  assign timeout_hit = (state == REQ) && !sd_ack &&
                       (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  // The counter stays at zero outside REQ, so each REQ entry starts from 0.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= timeout_hit;
      if (state == REQ) tmo_cnt <= tmo_cnt + 24'd1;
      else              tmo_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_pulse   = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      dir_wr     <= 1'b0;
      sd_lba     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 || req1)) begin
        grant  <= pick;
        dir_wr <= pick_wr;
        sd_lba <= pick ? r1_lba : r0_lba;
      end
      if (state == DONE || timeout_hit) last_grant <= grant;
    end
  end

  always_comb begin
    state_nx = state;
    sd_rd    = 1'b0;
    sd_wr    = 1'b0;
    r0_done  = 1'b0;
    r1_done  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (req0 || req1) state_nx = REQ;
      end
      REQ: begin
        sd_rd = ~dir_wr;
        sd_wr = dir_wr;
        if (sd_ack)           state_nx = XFER;
        else if (timeout_hit) state_nx = IDLE;
      end
      XFER: begin
        if (!sd_ack) state_nx = DONE;
      end
      DONE: begin
        r0_done  = ~grant;
        r1_done  = grant;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign r0_err = err_pulse & ~grant;
  assign r1_err = err_pulse & grant;

  // Buffer steering has zero latency; hps_io only drives the bus while sd_ack is high.
  assign fwd = ((state == REQ) || (state == XFER)) && sd_ack;

  always_comb begin
    r0_buff_addr = '0;
    r0_buff_dout = '0;
    r0_buff_wr   = 1'b0;
    r1_buff_addr = '0;
    r1_buff_dout = '0;
    r1_buff_wr   = 1'b0;
    sd_buff_din  = '0;
    if (fwd) begin
      if (grant) begin
        r1_buff_addr = sd_buff_addr;
        r1_buff_dout = sd_buff_dout;
        r1_buff_wr   = sd_buff_wr;
        sd_buff_din  = r1_buff_din;
      end else begin
        r0_buff_addr = sd_buff_addr;
        r0_buff_dout = sd_buff_dout;
        r0_buff_wr   = sd_buff_wr;
        sd_buff_din  = r0_buff_din;
      end
    end
  end

endmodule
